// File: rtl/cf_fft_phase_demux_pkg.sv
// Shared FFT control definitions: phase-code defaults for the 1024-point,
// 8-phase configuration and the phase-to-slot offset mapping.
package cf_fft_phase_demux_pkg;

  localparam int FFT_POINTS     = 1024;
  localparam int PHASES_DEFAULT = 8;
  localparam int PW_DEFAULT     = 3;
  localparam int DW_DEFAULT     = 1;

  // Bit offset of slot `code` inside a packed frame of dw-wide slots.
  function automatic int slot_offset(input int code, input int dw);
    return code * dw;
  endfunction

endpackage

// File: rtl/cf_fft_phase_demux_if.sv
// Stream interface of the phase demux: serial per-phase values in, assembled frame out.
interface cf_fft_phase_demux_if #(
  parameter int PHASES = cf_fft_phase_demux_pkg::PHASES_DEFAULT,
  parameter int DW     = cf_fft_phase_demux_pkg::DW_DEFAULT
);

  logic                 in_valid;
  logic [DW-1:0]        in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [PHASES*DW-1:0] out_data;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/cf_fft_phase_counter.sv
// Modulo-PHASES phase-code counter with enable and synchronous clear;
// shared by the demux and the mux-side sequencers.
module cf_fft_phase_counter
  import cf_fft_phase_demux_pkg::*;
#(
  parameter int PHASES = PHASES_DEFAULT,
  parameter int PW     = PW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          en,
  output logic [PW-1:0] phase,
  output logic          last
);

  assign last = (phase == PW'(PHASES - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of block ordering in simulation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (en) begin
      phase <= last ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/cf_fft_phase_demux.sv
// Phase demux: writes each accepted value into the slot of the live phase code
// and hands completed frames to a one-deep hold stage on a valid/ready output.
module cf_fft_phase_demux
  import cf_fft_phase_demux_pkg::*;
#(
  parameter int PHASES = PHASES_DEFAULT,
  parameter int PW     = PW_DEFAULT,
  parameter int DW     = DW_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  output logic [PW-1:0]        phase,
  cf_fft_phase_demux_if.slave  bus
);

  localparam int FW = PHASES * DW;

  logic [FW-1:0] slots;
  logic [FW-1:0] frame_final;
  logic          collect_full;
  logic          last;
  logic          accept;
  logic          write;
  logic          complete;
  logic          drain;
  logic          hold_free;
  logic          transfer;

  // A stalled full collect stage blocks input only while hold also cannot drain.
  assign bus.in_ready = !(collect_full && bus.out_valid && !bus.out_ready);

  assign accept    = bus.in_valid && bus.in_ready;
  assign write     = accept && !clear;
  assign complete  = write && last;
  assign drain     = bus.out_valid && bus.out_ready;
  assign hold_free = !bus.out_valid || bus.out_ready;
  assign transfer  = collect_full && drain && !clear;

  cf_fft_phase_counter #(
    .PHASES (PHASES),
    .PW     (PW)
  ) u_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .en      (accept),
    .phase   (phase),
    .last    (last)
  );

  // NOTE: the default assignment comes first so no path leaves frame_final
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    frame_final = slots;
    frame_final[slot_offset(PHASES - 1, DW) +: DW] = bus.in_data;
  end

  // NOTE: the slot storage is reset explicitly because an all-zero frame is
  // the defined post-reset state, not just a simulation convenience.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slots <= '0;
    end else if (write) begin
      slots[slot_offset(int'(phase), DW) +: DW] <= bus.in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      collect_full <= 1'b0;
    end else if (clear) begin
      collect_full <= 1'b0;
    end else if (complete && !hold_free) begin
      collect_full <= 1'b1;
    end else if (transfer) begin
      collect_full <= 1'b0;
    end
  end

  // Slots still hold the parked frame on a transfer cycle: the only write that
  // can coincide goes to slot 0 and lands after the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (complete && hold_free) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= frame_final;
    end else if (transfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= slots;
    end else if (drain) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cf_fft_phase_demux.sv
// Self-checking bench for cf_fft_phase_demux: directed scenarios plus a random
// phase, all compared against a frame-level reference model.
module tb_cf_fft_phase_demux;

  localparam int PHASES = 8;
  localparam int PW     = 3;
  localparam int DW     = 1;
  localparam int FW     = PHASES * DW;

  logic          clock;
  logic          reset_n;
  logic          clear;
  logic [PW-1:0] phase;

  cf_fft_phase_demux_if #(.PHASES(PHASES), .DW(DW)) bus ();

  cf_fft_phase_demux #(
    .PHASES (PHASES),
    .PW     (PW),
    .DW     (DW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .phase   (phase),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: slot array, a snapshot of a parked frame, and the hold frame.
  int            m_phase;
  logic [DW-1:0] m_slot [PHASES];
  bit            m_cfull;
  logic [FW-1:0] m_cframe;
  bit            m_hv;
  logic [FW-1:0] m_hd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] pack_slots();
    logic [FW-1:0] v;
    for (int k = 0; k < PHASES; k++) v[k*DW +: DW] = m_slot[k];
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    for (int k = 0; k < PHASES; k++) m_slot[k] = '0;
    m_cfull  = 0;
    m_cframe = '0;
    m_hv     = 0;
    m_hd     = '0;
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic clr);
    bit exp_ready, acc, drain, done;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    clear         = clr;
    #2;
    exp_ready = !(m_cfull && m_hv && !ordy);
    check("in_ready",  64'(bus.in_ready),  64'(exp_ready));
    check("out_valid", 64'(bus.out_valid), 64'(m_hv));
    check("out_data",  64'(bus.out_data),  64'(m_hd));
    check("phase",     64'(phase),         64'(m_phase));
    acc   = iv && exp_ready;
    drain = m_hv && ordy;
    done  = 0;
    if (clr) begin
      m_phase = 0;
      m_cfull = 0;
      if (drain) m_hv = 0;
    end else begin
      if (acc) begin
        m_slot[m_phase] = id;
        if (m_phase == PHASES - 1) begin
          done    = 1;
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
      if (done && (!m_hv || drain)) begin
        m_hd = pack_slots();
        m_hv = 1;
      end else if (done) begin
        m_cfull  = 1;
        m_cframe = pack_slots();
      end else if (m_cfull && drain) begin
        m_hd    = m_cframe;
        m_hv    = 1;
        m_cfull = 0;
      end else if (drain) begin
        m_hv = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  logic [7:0]  t1_data;
  logic [16:0] ov_hist;

  initial begin
    reset_n       = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_reset();
    #12 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Reset state
    check("rst_phase",     64'(phase),         64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);

    // 1: single frame 1,0,1,1,0,0,1,0
    t1_data = 8'b01001101;
    for (int i = 0; i < 8; i++) step(1'b1, t1_data[i], 1'b1, 1'b0);
    check("t1_out_valid", 64'(bus.out_valid), 64'd1);
    check("t1_out_data",  64'(bus.out_data),  64'h4d);
    check("t1_phase",     64'(phase),         64'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_pulse_end", 64'(bus.out_valid), 64'd0);

    // 2: two back-to-back frames, continuous input
    for (int i = 0; i < 17; i++) begin
      step(i < 16, DW'($urandom), 1'b1, 1'b0);
      ov_hist[i] = bus.out_valid;
    end
    check("t2_pulses", 64'(ov_hist), 64'h08080);

    // 3: stalled output, three frames offered
    for (int i = 0; i < 24; i++) begin
      step(1'b1, DW'($urandom), 1'b0, 1'b0);
      if (i == 15) check("t3_blocked", 64'(bus.in_ready), 64'd0);
    end
    check("t3_still_blocked", 64'(bus.in_ready), 64'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_reloaded", 64'(bus.out_valid), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_ready_back", 64'(bus.in_ready), 64'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // 4: clear after five accepts, with a colliding input value
    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("t4_phase_cleared", 64'(phase), 64'd0);
    for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
    check("t4_frame", 64'(bus.out_valid), 64'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // 5: final accept coincides with draining a full hold
    for (int i = 0; i < 15; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b1, DW'($urandom), 1'b1, 1'b0);
    check("t5_no_bubble", 64'(bus.out_valid), 64'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // 6: asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("t6_phase",     64'(phase),         64'd0);
    check("t6_out_valid", 64'(bus.out_valid), 64'd0);
    check("t6_out_data",  64'(bus.out_data),  64'd0);
    check("t6_in_ready",  64'(bus.in_ready),  64'd1);
    model_reset();
    @(posedge clock);
    #4 reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 9; i++) step(i < 8, DW'($urandom), 1'b1, 1'b0);

    // Random traffic with back-pressure and occasional clears
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), DW'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
